fpmul_pipe: RTL

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshaking, round-to-nearest-even and exception flags. It is the streaming successor to the combinational single-precision multiplier used in the convolution datapath. It sits between the operand fetch logic and the accumulator, accepts one operand pair per cycle, and tolerates accumulator back-pressure.

---
 rtl/fpmul_pkg.sv | 40 ++++
 rtl/fpmul_pipe_round.sv | 49 ++++
 rtl/fpmul_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fpmul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand classes, exponent bias and the canonical NaN encoding.
package fpmul_pkg;

  // Operand / result class
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_t;

  // Widest word the NaN builder can produce
  localparam int FP_MAX_W = 64;

  // Exponent bias for a given exponent field width
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set
  function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] v;
    v = (((FP_MAX_W)'(1) << exp_w) - (FP_MAX_W)'(1)) << man_w;
    v = v | ((FP_MAX_W)'(1) << (man_w - 1));
    return v;
  endfunction

  // Classify one operand from its field summaries (denormals count as zero)
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_zero);
    fp_class_t c;
    if (exp_zero)      c = CLS_ZERO;
    else if (!exp_ones) c = CLS_NORM;
    else if (man_zero)  c = CLS_INF;
    else                c = CLS_NAN;
    return c;
  endfunction

endpackage

// File: rtl/fpmul_pipe_round.sv
// Combinational normalise-and-round stage: takes the raw mantissa product
// and biased exponent sum, produces the rounded fraction, the final
// exponent field and range flags (round-to-nearest-even).
module fp_round_norm
  import fpmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]      i_p,
  input  logic signed [EXP_W+1:0] i_e,
  output logic [MAN_W-1:0]        o_man,
  output logic [EXP_W-1:0]        o_exp,
  output logic                    o_ovf,
  output logic                    o_unf
);

  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_OVF = EW'((1 << EXP_W) - 1);

  logic [PW-2:0]          w_pn;     // product below the hidden one, left-aligned
  logic signed [EW-1:0]   w_e_norm;
  logic [MAN_W-1:0]       w_frac;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_inc;
  logic [MAN_W:0]         w_sum;
  logic signed [EW-1:0]   w_e_fin;

  // Product lies in [1,4): drop the leading one, aligning 2.x results by one bit
  assign w_pn     = i_p[PW-1] ? i_p[PW-2:0] : {i_p[PW-3:0], 1'b0};
  assign w_e_norm = i_e + $signed({{(EW-1){1'b0}}, i_p[PW-1]});

  assign w_frac   = w_pn[PW-2 -: MAN_W];
  assign w_guard  = w_pn[MAN_W];
  assign w_sticky = |w_pn[MAN_W-1:0];
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);

  // A carry out of the fraction means the mantissa wrapped to 1.0 x 2
  assign w_sum    = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
  assign w_e_fin  = w_e_norm + $signed({{(EW-1){1'b0}}, w_sum[MAN_W]});

  assign o_man = w_sum[MAN_W-1:0];
  assign o_exp = w_e_fin[EXP_W-1:0];
  assign o_ovf = (w_e_fin >= E_OVF);
  assign o_unf = w_e_fin[EW-1] | (w_e_fin == '0);

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage streaming floating-point multiplier with valid/ready flow
// control. S1 classifies and multiplies, S2 normalises and rounds, S3
// packs the result and exception flags into the output register. A single
// global stall freezes every stage while the consumer holds off.
module fpmul_pipe
  import fpmul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] a_in,
  input  logic [EXP_W+MAN_W:0] b_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] c_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  output logic                 unf,
  output logic                 inv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2*MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E   = EW'(fp_bias(EXP_W));
  localparam logic [W-1:0]  NAN_WORD = W'(fp_canon_nan(EXP_W, MAN_W));

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    fp_class_t            cls;
    logic signed [EW-1:0] e;
    logic [PW-1:0]        p;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    fp_class_t        cls;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             ovf;
    logic             unf;
  } s2_t;

  logic w_stall;
  s1_t  r_s1, w_s1;
  s2_t  r_s2, w_s2;

  logic             r_out_valid;
  logic [W-1:0]     r_c_out;
  logic             r_ovf, r_unf, r_inv;

  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [MAN_W-1:0] w_man_a, w_man_b;
  fp_class_t        w_cls_a, w_cls_b;

  logic [MAN_W-1:0] w_rn_man;
  logic [EXP_W-1:0] w_rn_exp;
  logic             w_rn_ovf, w_rn_unf;

  logic [W-1:0]     w_c;
  logic             w_ovf, w_unf, w_inv;

  // Handshake: everything freezes while a result waits on the consumer
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall & ~rst;

  assign w_exp_a = a_in[W-2 -: EXP_W];
  assign w_exp_b = b_in[W-2 -: EXP_W];
  assign w_man_a = a_in[MAN_W-1:0];
  assign w_man_b = b_in[MAN_W-1:0];
  assign w_cls_a = fp_classify(w_exp_a == '0, w_exp_a == '1, w_man_a == '0);
  assign w_cls_b = fp_classify(w_exp_b == '0, w_exp_b == '1, w_man_b == '0);

  // S1 input: resolve the special-case class, multiply mantissas, sum exponents
  always_comb begin
    w_s1       = '0;
    w_s1.valid = in_valid & in_ready;
    w_s1.sign  = a_in[W-1] ^ b_in[W-1];
    w_s1.p     = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});
    w_s1.e     = $signed({2'b00, w_exp_a} + {2'b00, w_exp_b} - BIAS_E);
    if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
        (w_cls_a == CLS_INF && w_cls_b == CLS_ZERO) ||
        (w_cls_a == CLS_ZERO && w_cls_b == CLS_INF))
      w_s1.cls = CLS_NAN;
    else if (w_cls_a == CLS_INF || w_cls_b == CLS_INF)
      w_s1.cls = CLS_INF;
    else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_ZERO)
      w_s1.cls = CLS_ZERO;
    else
      w_s1.cls = CLS_NORM;
  end

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_p   (r_s1.p),
    .i_e   (r_s1.e),
    .o_man (w_rn_man),
    .o_exp (w_rn_exp),
    .o_ovf (w_rn_ovf),
    .o_unf (w_rn_unf)
  );

  // S2 input: carry the class forward alongside the rounded mantissa
  always_comb begin
    w_s2       = '0;
    w_s2.valid = r_s1.valid;
    w_s2.sign  = r_s1.sign;
    w_s2.cls   = r_s1.cls;
    w_s2.exp   = w_rn_exp;
    w_s2.man   = w_rn_man;
    w_s2.ovf   = w_rn_ovf;
    w_s2.unf   = w_rn_unf;
  end

  // S3 input: pack the final word; range flags only apply to the normal path
  always_comb begin
    w_c   = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    case (r_s2.cls)
      CLS_NAN: begin
        w_c   = NAN_WORD;
        w_inv = 1'b1;
      end
      CLS_INF:  w_c = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: w_c = {r_s2.sign, {(W-1){1'b0}}};
      default: begin
        if (r_s2.ovf) begin
          w_c   = {r_s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_ovf = 1'b1;
        end else if (r_s2.unf) begin
          w_c   = {r_s2.sign, {(W-1){1'b0}}};
          w_unf = 1'b1;
        end else begin
          w_c   = {r_s2.sign, r_s2.exp, r_s2.man};
        end
      end
    endcase
  end

  // S1 register
  always_ff @(posedge clk) begin
    if (rst)           r_s1.valid <= 1'b0;
    else if (!w_stall) r_s1       <= w_s1;
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (rst)           r_s2.valid <= 1'b0;
    else if (!w_stall) r_s2       <= w_s2;
  end

  // S3 output register; held stable while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_c_out     <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_inv       <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s2.valid;
      r_c_out     <= w_c;
      r_ovf       <= w_ovf;
      r_unf       <= w_unf;
      r_inv       <= w_inv;
    end
  end

  assign out_valid = r_out_valid;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign unf       = r_unf;
  assign inv       = r_inv;

endmodule
